// File: rtl/sort_pkg.sv
// Shared parameters and types for the sort_ctrl / sort_stage min-extraction sorter.
package sort_pkg;
  localparam int M  = 4;
  localparam int N  = 8;
  localparam int W  = $clog2(N);
  localparam int CW = $clog2(M + 1);

  typedef logic [N-1:0]         key_t;
  typedef logic [M-1:0][N-1:0]  chi_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sort_ctrl_state_t;
endpackage

// File: rtl/sort_ctrl_if.sv
// Load / sorted-stream handshake bundle; master = key source and sink side, slave = sort_ctrl.
interface sort_ctrl_if;
  logic                i_valid;
  logic                o_ready;
  sort_pkg::chi_t      i_chi;
  logic                o_valid;
  logic                i_ready;
  sort_pkg::key_t      o_key;
  logic                o_last;
  logic                i_abort;
  logic                o_busy;

  modport master (
    output i_valid, i_chi, i_ready, i_abort,
    input  o_ready, o_valid, o_key, o_last, o_busy
  );

  modport slave (
    input  i_valid, i_chi, i_ready, i_abort,
    output o_ready, o_valid, o_key, o_last, o_busy
  );
endinterface

// File: rtl/sort_stage.sv
// Combinational min-extraction: returns the smallest key and the matrix with one copy of it removed.
module sort_stage
  import sort_pkg::*;
(
  input  chi_t i_chi,
  output key_t o_y_q,
  output chi_t o_chi
);
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  logic [IW-1:0] min_idx;

  // A removed slot is filled with all-ones: it can only tie with a genuine maximum key,
  // and the controller extracts exactly M keys, so emitted values stay correct.
  always_comb begin
    min_idx = '0;
    o_y_q   = i_chi[0];
    for (int m = 1; m < M; m++) begin
      if (i_chi[m] < o_y_q) begin
        o_y_q   = i_chi[m];
        min_idx = IW'(m);
      end
    end
    o_chi          = i_chi;
    o_chi[min_idx] = '1;
  end
endmodule

// File: rtl/sort_ctrl.sv
// Loads one block of M keys, then emits them sorted one per cycle; first key two cycles after load.
// Output register holds key/valid/last while the sink stalls; each stall cycle pauses the iteration.
module sort_ctrl
  import sort_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  sort_ctrl_if.slave  bus
);
  localparam logic [CW-1:0] LAST_IDX = CW'(M - 1);

  sort_ctrl_state_t state_q, state_d;
  chi_t             chi_q, chi_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  key_t             key_q, key_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;

  key_t             stage_y;
  chi_t             stage_chi;
  logic             adv;

  sort_stage u_stage (
    .i_chi (chi_q),
    .o_y_q (stage_y),
    .o_chi (stage_chi)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      chi_q   <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chi_q   <= chi_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  // adv depends only on registered valid and i_ready, never feeding o_valid/o_key combinationally.
  assign adv = !vld_q || bus.i_ready;

  always_comb begin
    state_d = state_q;
    chi_d   = chi_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    vld_d   = vld_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          chi_d   = bus.i_chi;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          key_d  = stage_y;
          vld_d  = 1'b1;
          chi_d  = stage_chi;
          cnt_d  = cnt_q + CW'(1);
          last_d = (cnt_q == LAST_IDX);
          if (cnt_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.i_ready) begin
          vld_d   = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.i_abort) begin
      state_d = IDLE;
      chi_d   = chi_q;
      vld_d   = 1'b0;
      last_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  // Gated by reset so the source sees no readiness while the block is held in reset.
  assign bus.o_ready = i_rst_n && (state_q == IDLE);
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_valid = vld_q;
  assign bus.o_key   = key_q;
  assign bus.o_last  = last_q;
endmodule
